// File: rtl/program_loader.sv
// Run-time program loader: turns a length-prefixed, XOR-checksummed byte stream
// into little-endian instruction words written through the program memory port.
module program_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic                  CpuHold
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [16:0]     DEPTH_L   = 17'(MEMORY_DEPTH);
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [DATA_WIDTH-1:0] BYTES_W = DATA_WIDTH'(BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           idx_q, idx_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic [7:0]            xor_q, xor_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] waddr_q, waddr_d;
  logic                  we_q, we_d;

  logic                  busy;
  logic                  accept;
  logic [15:0]           len_full;
  logic [DATA_WIDTH-1:0] asm_word;

  always_comb begin
    busy     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
               (state_q == S_DATA)   || (state_q == S_CHECK);
    accept   = ByteValid && busy;
    len_full = {ByteIn, len_q[7:0]};

    // Current word with the incoming byte dropped into its lane.
    asm_word = word_q;
    for (int b = 0; b < BYTES; b++) begin
      if (bcnt_q == BCW'(b)) asm_word[b*8 +: 8] = ByteIn;
    end

    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    xor_d   = xor_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    we_d    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          state_d = S_LEN_LO;
          len_d   = '0;
          idx_d   = '0;
          bcnt_d  = '0;
          xor_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = ByteIn;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = len_full;
          if ({1'b0, len_full} > DEPTH_L) state_d = S_ERROR;
          else if (len_full == 16'd0)     state_d = S_CHECK;
          else                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d  = xor_q ^ ByteIn;
          word_d = asm_word;
          if (bcnt_q == LAST_BYTE) begin
            // Word complete: the strobe goes out next cycle with this index.
            bcnt_d  = '0;
            wdata_d = asm_word;
            waddr_d = DATA_WIDTH'(idx_q) * BYTES_W;
            we_d    = 1'b1;
            idx_d   = idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) state_d = S_CHECK;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end
      end
      S_CHECK: begin
        if (accept) state_d = (ByteIn == xor_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      xor_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      xor_q   <= xor_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
    end
  end

  assign ByteReady    = busy;
  assign Busy         = busy;
  assign Done         = (state_q == S_DONE);
  assign Error        = (state_q == S_ERROR);
  assign CpuHold      = (state_q != S_DONE);
  assign WriteEnable  = we_q;
  assign WriteAddress = waddr_q;
  assign WriteData    = wdata_q;

endmodule
